muldiv_sequencer: RTL and testbench

Sequencer that owns the architectural HI/LO registers and shares one operand bus between the multi-cycle multiplier and divider units. It accepts MULT/DIV/MTHI/MTLO operations from the CPU control unit, launches the selected unit with a one-cycle start pulse, and waits for its done level. It then commits the result into HI/LO and signals completion. The control unit stalls on `busy` for MFHI/MFLO hazards.

---
 rtl/muldiv_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Owns the architectural HI/LO registers and shares one registered operand
// bus between a multi-cycle multiplier and divider. Accepts MULT, DIV, MTHI
// and MTLO requests, pulses the selected unit's start for one cycle, waits
// for its done level and commits the result into HI/LO.
//
// Optional build macro: MULDIV_TIMEOUT_EN
//   When defined, a watchdog aborts a WAIT that lasts TIMEOUT cycles without
//   the unit's done. HI/LO are left unchanged and timeout_err is set.
//   When undefined, WAIT lasts until done and timeout_err is tied low.

module muldiv_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clock,
  input  logic             reset,        // asynchronous, active low
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             mult_start,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  output logic             div_start,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout_err
);

  // Operation encodings presented by the control unit
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10,
    ST_COMMIT = 2'b11
  } stateT;

  stateT state;
  stateT nextState;

  // Kind of the op in flight: 1 = divider owns the operation, 0 = multiplier
  logic opIsDiv;
  // Handshake edge: request seen while idle
  logic accept;
  // Divisor of the presented request is zero
  logic opBZero;

  // Done/result of whichever unit owns the in-flight op
  logic             unitDone;
  logic [WIDTH-1:0] unitHi;
  logic [WIDTH-1:0] unitLo;

  assign opBZero  = (op_b == {WIDTH{1'b0}});
  assign unitDone = opIsDiv ? div_done : mult_done;
  assign unitHi   = opIsDiv ? div_hi   : mult_hi;
  assign unitLo   = opIsDiv ? div_lo   : mult_lo;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT + 1);

  // Cycles spent in WAIT; last WAIT cycle before abort holds TIMEOUT-1
  logic [CntW-1:0] waitCnt;
  logic            waitExpired;
  logic            timeoutFire;

  assign waitExpired = (waitCnt == CntW'(TIMEOUT - 1));
`else
  // Watchdog not built: the depth parameter has no consumer in this build
  logic [31:0] unusedTimeout;
  assign unusedTimeout = 32'(TIMEOUT);
`endif

  // State register; reset forces IDLE so any start pulse is cut at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state decode and the state-decoded handshake/strobe outputs
  always_comb begin
    nextState  = state;
    op_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    mult_start = 1'b0;
    div_start  = 1'b0;
    accept     = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    timeoutFire = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        op_ready = 1'b1;
        busy     = 1'b0;
        if (op_valid) begin
          accept = 1'b1;
          case (op_code)
            OP_MULT: nextState = ST_LAUNCH;
            OP_DIV: begin
              // A zero divisor never reaches the divider
              if (opBZero) begin
                nextState = ST_COMMIT;
              end else begin
                nextState = ST_LAUNCH;
              end
            end
            // MTHI/MTLO complete at the accept edge itself
            default: nextState = ST_COMMIT;
          endcase
        end else begin
          nextState = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        mult_start = ~opIsDiv;
        div_start  = opIsDiv;
        nextState  = ST_WAIT;
      end
      ST_WAIT: begin
        // Done only counts here: units keep a stale done high until
        // they sample their start, which has happened by the first WAIT edge
        if (unitDone) begin
          nextState = ST_COMMIT;
        end else begin
`ifdef MULDIV_TIMEOUT_EN
          if (waitExpired) begin
            timeoutFire = 1'b1;
            nextState   = ST_COMMIT;
          end else begin
            nextState = ST_WAIT;
          end
`else
          nextState = ST_WAIT;
`endif
        end
      end
      ST_COMMIT: begin
        done      = 1'b1;
        nextState = ST_IDLE;
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

  // Operand bus, op kind, HI/LO and the divide-by-zero flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      unit_a   <= {WIDTH{1'b0}};
      unit_b   <= {WIDTH{1'b0}};
      opIsDiv  <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      div_zero <= 1'b0;
    end else if (accept) begin
      // Operands stay on the bus until the next accept
      unit_a   <= op_a;
      unit_b   <= op_b;
      opIsDiv  <= (op_code == OP_DIV);
      div_zero <= (op_code == OP_DIV) && opBZero;
      case (op_code)
        OP_MTHI: hi <= op_a;
        OP_MTLO: lo <= op_a;
        default: begin
          hi <= hi;
          lo <= lo;
        end
      endcase
    end else if ((state == ST_WAIT) && unitDone) begin
      hi <= unitHi;
      lo <= unitLo;
    end else begin
      hi <= hi;
      lo <= lo;
    end
  end

`ifdef MULDIV_TIMEOUT_EN
  // Watchdog counter (restarted on the way into WAIT) and sticky abort flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitCnt     <= {CntW{1'b0}};
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_LAUNCH) begin
        waitCnt <= {CntW{1'b0}};
      end else if (state == ST_WAIT) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= waitCnt;
      end
      if (accept) begin
        timeout_err <= 1'b0;
      end else if (timeoutFire) begin
        timeout_err <= 1'b1;
      end else begin
        timeout_err <= timeout_err;
      end
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: behavioural 31-cycle multiplier
// and 6-cycle divider models, directed op sequence, scoreboard of expected
// results popped when the sequencer signals done.

module tb_muldiv_sequencer;

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        mult_start;
  logic        mult_done = 1'b0;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        div_start;
  logic        div_done = 1'b0;
  logic [31:0] div_hi = 32'd0;
  logic [31:0] div_lo = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout_err;

  muldiv_sequencer #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clock      (clock),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_start  (div_start),
    .div_done   (div_done),
    .div_hi     (div_hi),
    .div_lo     (div_lo),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int multStarts = 0;
  int divStarts = 0;
  int lastT0 = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mult_start === 1'b1) multStarts <= multStarts + 1;
    if (div_start === 1'b1) divStarts <= divStarts + 1;
  end

  // Multiplier model: done 31 edges after the edge sampling start;
  // done stays high until the next start is sampled
  logic        multNever = 1'b0;
  int          multCnt = 0;
  logic [63:0] mProd = 64'd0;
  assign mult_hi = mProd[63:32];
  assign mult_lo = mProd[31:0];

  always @(posedge clock) begin
    if (mult_start === 1'b1) begin
      mult_done <= 1'b0;
      multCnt   <= multNever ? 0 : 31;
      mProd     <= $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
    end else if (multCnt == 1) begin
      mult_done <= 1'b1;
      multCnt   <= 0;
    end else if (multCnt > 1) begin
      multCnt <= multCnt - 1;
    end
  end

  // Divider model: latency 6, LO = quotient, HI = remainder
  int divCnt = 0;
  always @(posedge clock) begin
    if (div_start === 1'b1) begin
      div_done <= 1'b0;
      divCnt   <= 6;
      if (unit_b != 32'd0) begin
        div_lo <= $signed(unit_a) / $signed(unit_b);
        div_hi <= $signed(unit_a) % $signed(unit_b);
      end else begin
        div_lo <= 32'hFFFFFFFF;
        div_hi <= unit_a;
      end
    end else if (divCnt == 1) begin
      div_done <= 1'b1;
      divCnt   <= 0;
    end else if (divCnt > 1) begin
      divCnt <= divCnt - 1;
    end
  end

  typedef struct {
    logic [31:0] eHi;
    logic [31:0] eLo;
    logic        eDz;
    logic        eTe;
    int          eLat;
    int          eMs;
    int          eDs;
  } expT;

  expT sbq[$];

  function automatic expT mk(input logic [31:0] h, input logic [31:0] l, input logic dz,
                             input logic te, input int lat, input int ms, input int ds);
    expT e;
    e.eHi = h; e.eLo = l; e.eDz = dz; e.eTe = te; e.eLat = lat; e.eMs = ms; e.eDs = ds;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one op, wait (bounded) for done, compare against the scoreboard
  task automatic runOp(input string tag, input logic [1:0] code, input logic [31:0] a,
                       input logic [31:0] b, input expT e);
    expT got;
    int n;
    int t0;
    int ms0;
    int ds0;
    logic early;
    logic rdyBad;
    logic [31:0] ph;
    logic [31:0] pl;
    sbq.push_back(e);
    ph = hi; pl = lo; ms0 = multStarts; ds0 = divStarts;
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin step(); n++; end
    chk({tag, " ready"}, op_ready, 1'b1);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
    step();
    t0 = cyc; lastT0 = t0;
    op_valid = 1'b0; op_code = 2'($urandom); op_a = $urandom; op_b = $urandom;
    early = 1'b0; rdyBad = 1'b0; n = 0;
    while (done !== 1'b1 && n < 200) begin
      if (hi !== ph || lo !== pl) early = 1'b1;
      if (op_ready !== 1'b0) rdyBad = 1'b1;
      step();
      n++;
    end
    got = sbq.pop_front();
    chk({tag, " latency"}, 64'(cyc - t0), 64'(got.eLat));
    chk({tag, " hi"}, hi, got.eHi);
    chk({tag, " lo"}, lo, got.eLo);
    chk({tag, " div_zero"}, div_zero, got.eDz);
    chk({tag, " timeout_err"}, timeout_err, got.eTe);
    chk({tag, " hilo_early"}, early, 1'b0);
    chk({tag, " ready_busy"}, rdyBad, 1'b0);
    step();
    chk({tag, " done_1cyc"}, done, 1'b0);
    chk({tag, " idle"}, {busy, op_ready}, 2'b01);
    chk({tag, " mult_starts"}, 64'(multStarts - ms0), 64'(got.eMs));
    chk({tag, " div_starts"}, 64'(divStarts - ds0), 64'(got.eDs));
  endtask

  int t0Hi;

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_a = 32'd0; op_b = 32'd0;
    #2;
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst strobes", {mult_start, div_start, done, busy, op_ready}, 5'b00001);
    chk("rst flags", {div_zero, timeout_err}, 2'b00);
    step(); step();
    reset = 1'b1;
    step();

    runOp("mult7x-3", 2'b00, 32'd7, 32'hFFFFFFFD,
          mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 33, 1, 0));
    chk("unit_a hold", unit_a, 32'd7);
    chk("unit_b hold", unit_b, 32'hFFFFFFFD);

    runOp("div100/0", 2'b01, 32'd100, 32'd0,
          mk(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0, 0, 0, 0));
    chk("div0 sticky", div_zero, 1'b1);

    // Multiplier done is still high from the first MULT
    runOp("mult_stale", 2'b00, 32'h00010000, 32'h00010000,
          mk(32'h00000001, 32'h00000000, 1'b0, 1'b0, 33, 1, 0));

    runOp("div100/7", 2'b01, 32'd100, 32'd7,
          mk(32'd2, 32'd14, 1'b0, 1'b0, 8, 0, 1));

    // Divider done is still high; the multiplier must be the one watched
    runOp("mult-5x-6", 2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA,
          mk(32'd0, 32'd30, 1'b0, 1'b0, 33, 1, 0));

    runOp("mthi", 2'b10, 32'h1234, 32'd9, mk(32'h1234, 32'd30, 1'b0, 1'b0, 0, 0, 0));
    t0Hi = lastT0;
    runOp("mtlo", 2'b11, 32'h5678, 32'd9, mk(32'h1234, 32'h5678, 1'b0, 1'b0, 0, 0, 0));
    chk("mthi_mtlo spacing", 64'(lastT0 - t0Hi), 64'd2);

    // Asynchronous reset in the middle of WAIT
    op_valid = 1'b1; op_code = 2'b00; op_a = 32'd9; op_b = 32'd9;
    step();
    op_valid = 1'b0;
    repeat (10) step();
    chk("pre-reset busy", busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("async rst hilo", {hi, lo}, 64'd0);
    chk("async rst bus", {unit_a, unit_b}, 64'd0);
    chk("async rst strobes", {mult_start, div_start, done, busy, op_ready}, 5'b00001);
    chk("async rst flags", {div_zero, timeout_err}, 2'b00);
    step();
    reset = 1'b1;
    step();
    chk("post-rst ready", op_ready, 1'b1);
    runOp("mult3x4", 2'b00, 32'd3, 32'd4, mk(32'd0, 32'd12, 1'b0, 1'b0, 33, 1, 0));

`ifdef MULDIV_TIMEOUT_EN
    multNever = 1'b1;
    runOp("mult_timeout", 2'b00, 32'd2, 32'd2, mk(32'd0, 32'd12, 1'b0, 1'b1, 41, 1, 0));
    multNever = 1'b0;
    runOp("mult_after_to", 2'b00, 32'd1, 32'd1, mk(32'd0, 32'd1, 1'b0, 1'b0, 33, 1, 0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
